frame_rx: RTL
=============

# frame_rx

Receive-side framing stage that sits directly upstream of the `checksum` comparator on the bus. It collects a three-byte frame (start-of-frame, data, check byte) from the byte stream and presents `data`/`crc` to `checksum`. It samples the comparator's `result` back as `chk_ok` and keeps saturating good/bad frame counters. It aborts incomplete frames on an inter-byte timeout.

## Interface
- `SOF`, default 8'h7E: start-of-frame byte value.
- `TIMEOUT`, default 16: consecutive cycles without `rx_valid` allowed mid-frame; range ≥ 2.
- `CNT_W`, default 8: width of the frame counters.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  incoming byte; qualified by `rx_valid`.
- `rx_valid`  in  1  one byte accepted per cycle when high; there is no backpressure.
- `chk_ok`  in  1  `result` from the downstream `checksum(data, crc)`; combinational.
- `data`  out  8  captured data byte; held until the next capture.
- `crc`  out  8  captured check byte; held until the next capture.
- `frame_valid`  out  1  one-cycle pulse; `data`/`crc` form a complete frame.
- `timeout_err`  out  1  one-cycle pulse when a partial frame is aborted.
- `busy`  out  1  high in GET_DATA and GET_CRC.
- `good_cnt`  out  CNT_W  frames with `chk_ok`=1; saturating.
- `bad_cnt`  out  CNT_W  frames with `chk_ok`=0; saturating.

## Operation
- FSM states are IDLE, GET_DATA, GET_CRC and CHECK. All outputs are registered or decoded from state.
- **IDLE**
  - `rx_valid` & `rx_byte`==SOF → GET_DATA.
  - Any other byte is discarded silently.
- **GET_DATA**
  - `rx_valid` → `data`←`rx_byte`, then → GET_CRC.
  - A byte equal to SOF is taken as data; there is no byte stuffing.
- **GET_CRC**
  - `rx_valid` → `crc`←`rx_byte`, then → CHECK.
- **CHECK** lasts exactly one cycle.
  - `frame_valid`=1 for this cycle.
  - At the closing edge, `chk_ok` is sampled:
    - 1 → `good_cnt`+1.
    - 0 → `bad_cnt`+1.
  - Each counter sticks at 2^CNT_W−1.
  - Next state:
    - `rx_valid` & `rx_byte`==SOF in this cycle → GET_DATA, so back-to-back frames lose no byte.
    - Otherwise → IDLE.
- **Timeout**
  - An idle timer counts cycles with `rx_valid`=0 while in GET_DATA or GET_CRC.
  - The timer clears on every accepted byte and on entering GET_DATA.
  - When it reaches TIMEOUT:
    - state → IDLE;
    - `timeout_err` pulses for one cycle (the cycle after the abort edge);
    - the counters are unchanged;
    - `data`/`crc` keep whatever was captured.
- **Reset** (`rst_n` low, any time, including mid-frame):
  - state IDLE, timer 0;
  - `data`=0, `crc`=0;
  - `frame_valid`=0, `timeout_err`=0, `busy`=0;
  - `good_cnt`=0, `bad_cnt`=0.
  - A partial frame is discarded. Bytes following the release of reset are treated as from IDLE.

## Timing
- The check byte accepted at edge N gives `frame_valid`=1 in the cycle between edges N and N+1. The counters update at edge N+1.
- `data` and `crc` are stable from edge N through at least edge N+1. `chk_ok` must settle within that cycle; `checksum` is combinational.
- Minimum frame spacing is 3 cycles (SOF may arrive in the CHECK cycle).
- Abort timing: with the last byte accepted at edge M and no further `rx_valid`, the abort edge is M+TIMEOUT. `timeout_err` is high for the following cycle.
- A byte arriving in the same cycle the timer reaches TIMEOUT wins: it is accepted and the timer clears.
- `busy` follows state with zero added latency.

## Test plan
- **Good frame.** Send 7E, AA, 9D (9D = AA^37) on consecutive cycles → `frame_valid` pulses once with `data`=AA, `crc`=9D; then `good_cnt`=1, `bad_cnt`=0.
- **Bad frame.** Send 7E, AD, 9B (correct value is 9A) → `frame_valid` pulses with `data`=AD, `crc`=9B; `bad_cnt`=1, `good_cnt` unchanged.
- **Leading garbage and SOF as data.** Send 00, 55, 7E, 7E, 49 (7E^37) → exactly one `frame_valid`, with `data`=7E, `crc`=49; `good_cnt`+1.
- **Timeout.** Send 7E, AA, then hold `rx_valid` low 16 cycles → `timeout_err` pulses once and `busy` drops. No `frame_valid`, counters unchanged. A following frame 7E, AF, 98 → `good_cnt`+1.
- **Reset mid-frame.** Send 7E, AA, pulse `rst_n` low between edges, then send 9D → all outputs 0 during reset and after release. 9D is ignored (no `frame_valid`).
- **Back-to-back and saturation.** Build with CNT_W=2. Send five good frames with `rx_valid` continuously high, each SOF landing in the CHECK cycle → five `frame_valid` pulses, and `good_cnt` stays at 3.

Source files
------------

// File: rtl/frame_rx_if.sv
// Byte-stream and checksum-side signals for the receive framing stage.
interface frame_rx_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             chk_ok;
    logic [7:0]       data;
    logic [7:0]       crc;
    logic             frame_valid;
    logic             timeout_err;
    logic             busy;
    logic [CNT_W-1:0] good_cnt;
    logic [CNT_W-1:0] bad_cnt;

    modport master (
        output rx_byte, rx_valid, chk_ok,
        input  data, crc, frame_valid, timeout_err, busy, good_cnt, bad_cnt
    );

    modport slave (
        input  rx_byte, rx_valid, chk_ok,
        output data, crc, frame_valid, timeout_err, busy, good_cnt, bad_cnt
    );
endinterface

// File: rtl/frame_rx.sv
// Receive framing stage: collects SOF/data/check frames, presents data/crc to
// the downstream checksum comparator, counts good/bad frames and aborts
// partial frames after an inter-byte timeout.
module frame_rx #(
    parameter logic [7:0]  SOF     = 8'h7E,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    frame_rx_if.slave  bus
);
    localparam int unsigned     TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        GET_DATA,
        GET_CRC,
        CHECK
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       crc_q, crc_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;
    logic             tout_q, tout_d;
    logic             sof;

    assign sof = bus.rx_valid && (bus.rx_byte == SOF);

    // Next-state, capture, timeout and counter decisions.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        crc_d   = crc_q;
        good_d  = good_q;
        bad_d   = bad_q;
        tout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sof) begin
                    state_d = GET_DATA;
                    timer_d = '0;
                end
            end
            GET_DATA: begin
                if (bus.rx_valid) begin
                    data_d  = bus.rx_byte;
                    timer_d = '0;
                    state_d = GET_CRC;
                end else if (timer_q == TMAX) begin
                    // This is the TIMEOUT-th silent cycle: abort at this edge.
                    state_d = IDLE;
                    timer_d = '0;
                    tout_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GET_CRC: begin
                if (bus.rx_valid) begin
                    crc_d   = bus.rx_byte;
                    timer_d = '0;
                    state_d = CHECK;
                end else if (timer_q == TMAX) begin
                    state_d = IDLE;
                    timer_d = '0;
                    tout_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                if (bus.chk_ok) begin
                    if (good_q != '1) good_d = good_q + CNT_W'(1);
                end else begin
                    if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
                end
                timer_d = '0;
                // SOF in the check cycle starts the next frame immediately.
                state_d = sof ? GET_DATA : IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            data_q  <= '0;
            crc_q   <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            tout_q  <= tout_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.crc         = crc_q;
    assign bus.frame_valid = (state_q == CHECK);
    assign bus.busy        = (state_q == GET_DATA) || (state_q == GET_CRC);
    assign bus.timeout_err = tout_q;
    assign bus.good_cnt    = good_q;
    assign bus.bad_cnt     = bad_q;
endmodule
